// File: rtl/spi_reg_bridge_if.sv
// Bundles the SPI slave byte port, the register bus and the bridge status lines.
//   master : the bridge side; drives TX load, register strobes/address/data, busy, err.
//   slave  : the environment side; drives RX bytes, raw chip select and read data.
interface spi_reg_bridge_if;
  logic       rx_dv;      // one-cycle pulse, rx_byte valid
  logic [7:0] rx_byte;    // byte received on MOSI
  logic       spi_cs_n;   // raw, asynchronous chip select
  logic       tx_dv;      // one-cycle pulse, load tx_byte into the slave
  logic [7:0] tx_byte;    // next byte for MISO
  logic       reg_wr;     // one-cycle write strobe
  logic       reg_rd;     // one-cycle read strobe
  logic [6:0] reg_addr;   // register address
  logic [7:0] reg_wdata;  // write data, valid with reg_wr
  logic [7:0] reg_rdata;  // read data, valid one cycle after reg_rd
  logic       busy;       // frame active
  logic       err;        // byte received outside a frame

  modport master (
    input  rx_dv, rx_byte, spi_cs_n, reg_rdata,
    output tx_dv, tx_byte, reg_wr, reg_rd, reg_addr, reg_wdata, busy, err
  );

  modport slave (
    output rx_dv, rx_byte, spi_cs_n, reg_rdata,
    input  tx_dv, tx_byte, reg_wr, reg_rd, reg_addr, reg_wdata, busy, err
  );
endinterface

// File: rtl/spi_reg_bridge.sv
// SPI command decoder and register-bus master.
// Each chip-select frame starts with {RW, ADDR[6:0]}; following bytes are write data (RW=0)
// or dummies that clock out prefetched read data (RW=1). A status byte is loaded for MISO
// after reset and at every frame end so the next frame's command byte returns it.
//   clk_i  : system clock (>= 8x SPI clock)
//   rst_i  : asynchronous active-high reset
//   bus_io : spi_reg_bridge_if.master (RX/TX byte port, register bus, busy, err)
module spi_reg_bridge #(
  parameter logic [7:0] StatusByte = 8'hA5,
  parameter bit         AutoInc    = 1'b1
) (
  input logic              clk_i,
  input logic              rst_i,
  spi_reg_bridge_if.master bus_io
);

  typedef enum logic [2:0] {StIdle, StCmd, StWr, StRdIssue, StRdLoad, StRd} state_e;

  localparam logic [6:0] AddrStep = {6'd0, AutoInc};

  state_e     state_q, state_d;
  logic       cs_meta_q, cs_s_q;
  logic       init_q;
  logic       frame_end;

  logic       tx_dv_q, tx_dv_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       reg_wr_q, reg_wr_d;
  logic       reg_rd_q, reg_rd_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;

  // Synchronized CS high while a frame is open closes it, whatever the state.
  assign frame_end = (state_q != StIdle) && cs_s_q;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (!cs_s_q) state_d = StCmd;
      StCmd:     if (bus_io.rx_dv) state_d = bus_io.rx_byte[7] ? StRdIssue : StWr;
      StWr:      state_d = StWr;
      StRdIssue: state_d = StRdLoad;
      StRdLoad:  state_d = StRd;
      StRd:      if (bus_io.rx_dv) state_d = StRdIssue;
      default:   state_d = StIdle;
    endcase
    if (frame_end) state_d = StIdle;
  end

  // Output next-state logic; every output is registered below.
  always_comb begin
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    reg_wr_d  = 1'b0;
    wdata_d   = wdata_q;
    err_d     = 1'b0;
    busy_d    = ~cs_meta_q;  // tracks cs_s_q inverted, in the same clock
    // A write presents the old address with the strobe, then advances one cycle later.
    addr_d    = reg_wr_q ? addr_q + AddrStep : addr_q;

    case (state_q)
      StIdle: begin
        if (bus_io.rx_dv) err_d = 1'b1;
      end
      StCmd: begin
        if (bus_io.rx_dv) begin
          addr_d = bus_io.rx_byte[6:0];
          if (!bus_io.rx_byte[7]) begin
            tx_dv_d   = 1'b1;
            tx_byte_d = bus_io.rx_byte;
          end
        end
      end
      StWr: begin
        if (bus_io.rx_dv) begin
          reg_wr_d  = 1'b1;
          wdata_d   = bus_io.rx_byte;
          tx_dv_d   = 1'b1;
          tx_byte_d = bus_io.rx_byte;
        end
      end
      StRdLoad: begin
        tx_dv_d   = 1'b1;
        tx_byte_d = bus_io.reg_rdata;
      end
      StRd: begin
        if (bus_io.rx_dv) addr_d = addr_q + AddrStep;
      end
      default: ;
    endcase

    // Strobe is high exactly while the FSM sits in StRdIssue.
    reg_rd_d = (state_d == StRdIssue);

    // Status preload wins over any echo or read-data load.
    if (frame_end || init_q) begin
      tx_dv_d   = 1'b1;
      tx_byte_d = StatusByte;
    end
  end

  // Synchronizer and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cs_meta_q <= 1'b1;
      cs_s_q    <= 1'b1;
      init_q    <= 1'b1;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
      reg_wr_q  <= 1'b0;
      reg_rd_q  <= 1'b0;
      addr_q    <= 7'h00;
      wdata_q   <= 8'h00;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cs_meta_q <= bus_io.spi_cs_n;
      cs_s_q    <= cs_meta_q;
      init_q    <= 1'b0;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
      reg_wr_q  <= reg_wr_d;
      reg_rd_q  <= reg_rd_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign bus_io.tx_dv     = tx_dv_q;
  assign bus_io.tx_byte   = tx_byte_q;
  assign bus_io.reg_wr    = reg_wr_q;
  assign bus_io.reg_rd    = reg_rd_q;
  assign bus_io.reg_addr  = addr_q;
  assign bus_io.reg_wdata = wdata_q;
  assign bus_io.busy      = busy_q;
  assign bus_io.err       = err_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Self-checking bench for spi_reg_bridge: directed and randomized frames against a
// frame-level reference model (expected strobe/load events with their cycle numbers).
module tb_spi_reg_bridge;

  typedef struct packed {
    int         cyc;
    logic [6:0] addr;
    logic [7:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_init = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  spi_reg_bridge_if bus ();
  spi_reg_bridge_if bus0 ();

  spi_reg_bridge #(.StatusByte(8'hA5), .AutoInc(1'b1)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus_io(bus)
  );

  // Second instance with the address held, fed the same stimulus.
  spi_reg_bridge #(.StatusByte(8'hA5), .AutoInc(1'b0)) u_dut_hold (
    .clk_i (clk),
    .rst_i (rst),
    .bus_io(bus0)
  );

  assign bus0.rx_dv     = bus.rx_dv;
  assign bus0.rx_byte   = bus.rx_byte;
  assign bus0.spi_cs_n  = bus.spi_cs_n;
  assign bus0.reg_rdata = bus.reg_rdata;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file seen by the bridge; starts with contents addr + 0x40.
  logic [7:0] dev_mem [128];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 128; i++) dev_mem[i] <= 8'(i + 'h40);
    end else begin
      if (bus.reg_wr) dev_mem[bus.reg_addr] <= bus.reg_wdata;
      if (bus.reg_rd) bus.reg_rdata <= dev_mem[bus.reg_addr];
    end
  end

  // Observed event logs, sampled on the falling edge.
  ev_t wr_log[$], wr0_log[$], rd_log[$], tx_log[$], err_log[$];
  ev_t exp_wr[$], exp_wr0[$], exp_rd[$], exp_tx[$], exp_err[$];
  int  base [5];
  logic [7:0] ref_mem [128];
  logic [7:0] payload[$];

  function automatic ev_t mk(input int c, input logic [6:0] a, input logic [7:0] d);
    ev_t e;
    e.cyc = c; e.addr = a; e.data = d;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.reg_wr)  wr_log.push_back(mk(cyc, bus.reg_addr, bus.reg_wdata));
      if (bus0.reg_wr) wr0_log.push_back(mk(cyc, bus0.reg_addr, bus0.reg_wdata));
      if (bus.reg_rd)  rd_log.push_back(mk(cyc, bus.reg_addr, 8'h00));
      if (bus.tx_dv)   tx_log.push_back(mk(cyc, 7'h00, bus.tx_byte));
      if (bus.err)     err_log.push_back(mk(cyc, 7'h00, 8'h00));
    end
  end

  function automatic int log_size(input int s);
    case (s)
      0: return wr_log.size();
      1: return wr0_log.size();
      2: return rd_log.size();
      3: return tx_log.size();
      default: return err_log.size();
    endcase
  endfunction

  function automatic ev_t log_at(input int s, input int i);
    case (s)
      0: return wr_log[i];
      1: return wr0_log[i];
      2: return rd_log[i];
      3: return tx_log[i];
      default: return err_log[i];
    endcase
  endfunction

  function automatic int exp_size(input int s);
    case (s)
      0: return exp_wr.size();
      1: return exp_wr0.size();
      2: return exp_rd.size();
      3: return exp_tx.size();
      default: return exp_err.size();
    endcase
  endfunction

  function automatic ev_t exp_at(input int s, input int i);
    case (s)
      0: return exp_wr[i];
      1: return exp_wr0[i];
      2: return exp_rd[i];
      3: return exp_tx[i];
      default: return exp_err[i];
    endcase
  endfunction

  function automatic string qname(input int s);
    case (s)
      0: return "wr";
      1: return "wr_hold";
      2: return "rd";
      3: return "tx";
      default: return "err";
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mark();
    for (int s = 0; s < 5; s++) base[s] = log_size(s);
    exp_wr.delete(); exp_wr0.delete(); exp_rd.delete(); exp_tx.delete(); exp_err.delete();
  endtask

  task automatic cmp_all(input string tag);
    int  nl, ne;
    ev_t o, e;
    for (int s = 0; s < 5; s++) begin
      nl = log_size(s) - base[s];
      ne = exp_size(s);
      chk($sformatf("%s/%s_count", tag, qname(s)), nl, ne);
      for (int i = 0; i < ne && i < nl; i++) begin
        o = log_at(s, base[s] + i);
        e = exp_at(s, i);
        chk($sformatf("%s/%s[%0d]_cycle", tag, qname(s), i), o.cyc, e.cyc);
        chk($sformatf("%s/%s[%0d]_addr", tag, qname(s), i), {25'd0, o.addr}, {25'd0, e.addr});
        chk($sformatf("%s/%s[%0d]_data", tag, qname(s), i), {24'd0, o.data}, {24'd0, e.data});
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output int rc);
    rc = cyc;
    bus.rx_dv   = 1'b1;
    bus.rx_byte = b;
    tick();
    bus.rx_dv   = 1'b0;
  endtask

  task automatic gap();
    repeat ($urandom_range(3, 8)) tick();
  endtask

  task automatic cs_low(input string tag);
    bus.spi_cs_n = 1'b0;
    repeat (4) tick();
    chk({tag, "/busy_high"}, bus.busy, 1'b1);
  endtask

  // Raise CS; the status preload lands three cycles after the CS edge is driven.
  task automatic cs_high(input string tag);
    exp_tx.push_back(mk(cyc + 3, 7'h00, 8'hA5));
    bus.spi_cs_n = 1'b1;
    repeat (6) tick();
    chk({tag, "/busy_low"}, bus.busy, 1'b0);
  endtask

  task automatic write_frame(input string tag, input logic [6:0] a);
    int rc;
    logic [6:0] ad;
    mark();
    cs_low(tag);
    send_byte({1'b0, a}, rc);
    exp_tx.push_back(mk(rc + 1, 7'h00, {1'b0, a}));
    for (int i = 0; i < payload.size(); i++) begin
      gap();
      send_byte(payload[i], rc);
      ad = 7'(a + 7'(i));
      exp_wr.push_back(mk(rc + 1, ad, payload[i]));
      exp_wr0.push_back(mk(rc + 1, a, payload[i]));
      exp_tx.push_back(mk(rc + 1, 7'h00, payload[i]));
      ref_mem[ad] = payload[i];
    end
    gap();
    cs_high(tag);
    cmp_all(tag);
  endtask

  task automatic read_frame(input string tag, input logic [6:0] a, input int n);
    int rc;
    logic [6:0] ad;
    mark();
    cs_low(tag);
    send_byte({1'b1, a}, rc);
    exp_rd.push_back(mk(rc + 1, a, 8'h00));
    exp_tx.push_back(mk(rc + 3, 7'h00, ref_mem[a]));
    for (int i = 1; i <= n; i++) begin
      gap();
      send_byte(8'($urandom), rc);
      ad = 7'(a + 7'(i));
      exp_rd.push_back(mk(rc + 1, ad, 8'h00));
      exp_tx.push_back(mk(rc + 3, 7'h00, ref_mem[ad]));
    end
    gap();
    cs_high(tag);
    cmp_all(tag);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "/tx_dv"}, bus.tx_dv, 1'b0);
    chk({tag, "/tx_byte"}, bus.tx_byte, 8'h00);
    chk({tag, "/reg_wr"}, bus.reg_wr, 1'b0);
    chk({tag, "/reg_rd"}, bus.reg_rd, 1'b0);
    chk({tag, "/reg_addr"}, bus.reg_addr, 7'h00);
    chk({tag, "/reg_wdata"}, bus.reg_wdata, 8'h00);
    chk({tag, "/busy"}, bus.busy, 1'b0);
    chk({tag, "/err"}, bus.err, 1'b0);
  endtask

  initial begin
    int rc;
    int cc;
    logic [7:0] tx_before;

    bus.spi_cs_n = 1'b1;
    bus.rx_dv    = 1'b0;
    bus.rx_byte  = 8'h00;
    for (int i = 0; i < 128; i++) ref_mem[i] = 8'(i + 'h40);

    // Reset state, then status preload in the first cycle after release.
    repeat (3) tick();
    chk_all_zero("reset");
    mem_init = 1'b0;
    rst = 1'b0;
    tick();
    chk("init/tx_dv", bus.tx_dv, 1'b1);
    chk("init/tx_byte", bus.tx_byte, 8'hA5);
    chk("init/reg_wr", bus.reg_wr, 1'b0);
    chk("init/reg_rd", bus.reg_rd, 1'b0);
    chk("init/err", bus.err, 1'b0);
    tick();
    chk("init/tx_dv_pulse", bus.tx_dv, 1'b0);
    repeat (2) tick();

    // Directed write 0x12: 0x34, 0x56.
    payload = '{8'h34, 8'h56};
    write_frame("wr12", 7'h12);

    // Directed read at 0x05 with two dummies: loads 0x45, 0x46, 0x47.
    read_frame("rd05", 7'h05, 2);

    // Address wrap 0x7F -> 0x00 (held at 0x7F in the non-incrementing instance).
    payload = '{8'($urandom), 8'($urandom)};
    write_frame("wrap", 7'h7F);

    // Randomized frames.
    for (int f = 0; f < 6; f++) begin
      if ($urandom_range(0, 1) == 1) begin
        payload.delete();
        repeat ($urandom_range(1, 4)) payload.push_back(8'($urandom));
        write_frame($sformatf("rnd%0d_wr", f), 7'($urandom));
      end else begin
        read_frame($sformatf("rnd%0d_rd", f), 7'($urandom), $urandom_range(1, 4));
      end
    end

    // Byte with CS high: error pulse only, TX byte untouched.
    mark();
    tx_before = bus.tx_byte;
    send_byte(8'($urandom), rc);
    exp_err.push_back(mk(rc + 1, 7'h00, 8'h00));
    repeat (4) tick();
    cmp_all("idle_err");
    chk("idle_err/tx_byte", bus.tx_byte, tx_before);

    // Last write byte coincides with the synchronized CS rise.
    mark();
    cs_low("late");
    send_byte(8'h20, rc);
    exp_tx.push_back(mk(rc + 1, 7'h00, 8'h20));
    gap();
    send_byte(8'h9C, rc);
    exp_wr.push_back(mk(rc + 1, 7'h20, 8'h9C));
    exp_wr0.push_back(mk(rc + 1, 7'h20, 8'h9C));
    exp_tx.push_back(mk(rc + 1, 7'h00, 8'h9C));
    gap();
    cc = cyc;
    bus.spi_cs_n = 1'b1;
    tick();
    tick();
    send_byte(8'h3D, rc);
    exp_wr.push_back(mk(rc + 1, 7'h21, 8'h3D));
    exp_wr0.push_back(mk(rc + 1, 7'h20, 8'h3D));
    exp_tx.push_back(mk(cc + 3, 7'h00, 8'hA5));
    repeat (4) tick();
    // Bridge must be idle now: a further byte raises err.
    send_byte(8'h11, rc);
    exp_err.push_back(mk(rc + 1, 7'h00, 8'h00));
    repeat (4) tick();
    cmp_all("late");
    chk("late/tx_byte", bus.tx_byte, 8'hA5);

    // Reset asserted in the middle of a read burst.
    cs_low("rstmid");
    send_byte(8'h80 | 8'($urandom_range(0, 127)), rc);
    gap();
    send_byte(8'hFF, rc);
    rst = 1'b1;
    #1;
    chk_all_zero("rstmid_now");
    bus.spi_cs_n = 1'b1;
    repeat (4) tick();
    chk_all_zero("rstmid_hold");
    mark();
    rst = 1'b0;
    exp_tx.push_back(mk(cyc + 1, 7'h00, 8'hA5));
    repeat (8) tick();
    cmp_all("rstmid_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
